// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier sequencer. It computes (op_a * op_b) mod 2**XLEN and
// routes every add and every zero-test through an external single-cycle ALU.
module alu_mul_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product,
  output logic [2:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_src_a,
  output logic [XLEN-1:0] alu_src_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {IDLE, CHECK, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    mcand_q, mcand_d;
  logic [XLEN-1:0]    mplier_q, mplier_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]    product_q, product_d;
  logic [CNT_W-1:0]   iter_q, iter_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      iter_q    <= iter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    iter_d    = iter_q;
    alu_ctrl  = ALU_ADD;
    alu_src_a = '0;
    alu_src_b = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          iter_d   = '0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        // OR with zero lets the ALU zero flag report whether any multiplier bits remain
        alu_ctrl  = ALU_OR;
        alu_src_a = mplier_q;
        if (alu_zero) begin
          product_d = acc_q;
          state_d   = DONE;
        end else begin
          state_d = ACC;
        end
      end
      ACC: begin
        alu_ctrl  = ALU_ADD;
        alu_src_a = acc_q;
        alu_src_b = mplier_q[0] ? mcand_q : '0;
        acc_d     = alu_result;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        iter_d    = iter_q + 1'b1;
        state_d   = CHECK;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

  // The multiplier empties after at most XLEN shifts, so ACC is never entered with iter at XLEN
  a_iter_bound: assert property (@(posedge clk) disable iff (reset)
    (state_q == ACC) |-> (iter_q < CNT_W'(XLEN)));

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: a behavioural ALU closes the loop, a vector table
// checks products and latencies, and hand-written sequences cover held start and mid-op reset.
module tb_alu_mul_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [XLEN-1:0] op_a, op_b;
  logic            busy, done;
  logic [XLEN-1:0] product;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] alu_src_a, alu_src_b, alu_result;
  logic            alu_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .alu_ctrl(alu_ctrl),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Behavioural single-cycle ALU: add or bitwise OR, plus zero flag
  always_comb begin
    alu_result = (alu_ctrl == 3'b011) ? (alu_src_a | alu_src_b) : (alu_src_a + alu_src_b);
    alu_zero   = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    string           name;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] p;
    int              lat;
  } vec_t;

  // Start one multiply at the next negedge (cycle 0) and follow it to the done pulse.
  task automatic run_op(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_p, input int exp_lat,
                        input bit chk_hold, input logic [XLEN-1:0] hold_val);
    int lat, accs, k;
    bit busy_ok;
    k = -1;
    for (int i = 0; i < XLEN; i++) if (b[i]) k = i;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    chk({name, ".idle_busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    if (chk_hold) chk({name, ".product_hold"}, 64'(product), 64'(hold_val));
    lat = 1; accs = 0; busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (alu_ctrl == 3'b000) accs++;
      @(negedge clk);
      lat++;
    end
    chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({name, ".busy_in_done"}, 64'(busy), 64'd1);
    chk({name, ".busy_throughout"}, 64'(busy_ok), 64'd1);
    chk({name, ".acc_visits"}, 64'(accs), 64'(k + 1));
    chk({name, ".product"}, 64'(product), 64'(exp_p));
    $display("op %s: a=0x%08h b=0x%08h product=0x%08h latency=%0d", name, a, b, product, lat);
  endtask

  vec_t vecs[8];

  initial begin
    int   c;
    bit   done_seen;
    logic [2:0] exp_ctrl;

    vecs[0] = '{"mul_7x6",      32'd7,          32'd6,          32'd42,       8};
    vecs[1] = '{"b_zero",       32'h0000_1234,  32'd0,          32'd0,        2};
    vecs[2] = '{"all_ones",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,        66};
    vecs[3] = '{"mul_3x1",      32'd3,          32'd1,          32'd3,        4};
    vecs[4] = '{"mul_2x2",      32'd2,          32'd2,          32'd4,        6};
    vecs[5] = '{"wrap_2p32",    32'h0001_0000,  32'h0001_0000,  32'd0,        36};
    vecs[6] = '{"mul_12345x1000", 32'd12345,    32'd1000,       32'd12345000, 22};
    vecs[7] = '{"a_zero",       32'd0,          32'd5,          32'd0,        8};

    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.product", 64'(product), 64'd0);
    chk("reset.alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("reset.src_a", 64'(alu_src_a), 64'd0);
    chk("reset.src_b", 64'(alu_src_b), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, 1'b0, '0);

    // Back-to-back: product of the first op must hold while the second is in flight
    run_op("b2b_first", 32'd3, 32'd1, 32'd3, 4, 1'b0, '0);
    run_op("b2b_second", 32'd2, 32'd2, 32'd4, 6, 1'b1, 32'd3);

    // start held high: one op at a time, next accepted the cycle after done
    @(negedge clk);
    start = 1'b1; op_a = 32'd7; op_b = 32'd6;
    for (c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_ctrl = (c == 8) ? 3'b000 : ((c % 2 == 1) ? 3'b011 : 3'b000);
      chk($sformatf("held.ctrl_c%0d", c), 64'(alu_ctrl), 64'(exp_ctrl));
      chk($sformatf("held.done_c%0d", c), 64'(done), 64'(c == 8));
    end
    chk("held.product1", 64'(product), 64'd42);
    @(negedge clk);  // cycle 9: IDLE, held start accepted here
    chk("held.idle_c9", 64'(busy), 64'd0);
    for (c = 10; c <= 17; c++) begin
      @(negedge clk);
      chk($sformatf("held.done_c%0d", c), 64'(done), 64'(c == 17));
      if (c == 10) chk("held.check_c10", 64'(alu_ctrl), 64'd3);
    end
    start = 1'b0;
    chk("held.product2", 64'(product), 64'd42);
    @(negedge clk);
    chk("held.idle_c18", 64'(busy), 64'd0);
    @(negedge clk);
    chk("held.idle_c19", 64'(busy), 64'd0);
    $display("op held_start: two 7x6 ops, second accepted in cycle 9");

    // Reset in cycle 3 of a long multiply discards it
    @(negedge clk);
    start = 1'b1; op_a = 32'd5; op_b = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.done", 64'(done), 64'd0);
    chk("midreset.product", 64'(product), 64'd0);
    chk("midreset.alu_ctrl", 64'(alu_ctrl), 64'd0);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    chk("midreset.no_activity", 64'(done_seen), 64'd0);
    $display("op mid_reset: a=5 b=0x80000000 aborted, product=0x%08h", product);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
